// File: rtl/divider_iterative.sv
// divider_iterative
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   Produces one quotient bit per cycle. Shares the start/done/use handshake
//   with the iterative multiplier in Execute.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   startE         launch request, sampled only in IDLE
//   div_opcode     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   operand1       dividend (rs1)
//   operand2       divisor  (rs2)
//   result_divide  registered quotient/remainder
//   done           one-cycle pulse, result_divide valid in that cycle
//   div_use        high while an operation is in flight (pipeline stall)
//
// Optional feature:
//   DIV_EARLY_OUT_EN  divide-by-zero and signed overflow skip the iterations
//                     and finish one edge after launch.
module divider_iterative #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       div_opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result_divide,
    output logic             done,
    output logic             div_use
);

    localparam int unsigned      CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [1:0]       opcode;
    logic [WIDTH-1:0] dvd;           // dividend magnitude, becomes quotient
    logic [WIDTH-1:0] dvs;           // divisor magnitude
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dividend_raw;  // original rs1 for REM by zero
    logic             quot_neg;
    logic             rem_neg;
    logic             div_zero;
    logic             sgn_ovf;
    logic [CW-1:0]    count;

    // Launch decode
    logic             in_signed;
    logic             in_op1_neg;
    logic             in_op2_neg;
    logic             in_div_zero;
    logic             in_sgn_ovf;
    logic [WIDTH-1:0] in_abs1;
    logic [WIDTH-1:0] in_abs2;

    always_comb begin
        in_signed   = ~div_opcode[0];
        in_op1_neg  = in_signed & operand1[WIDTH-1];
        in_op2_neg  = in_signed & operand2[WIDTH-1];
        in_abs1     = in_op1_neg ? -operand1 : operand1;
        in_abs2     = in_op2_neg ? -operand2 : operand2;
        in_div_zero = (operand2 == '0);
        in_sgn_ovf  = in_signed && (operand1 == MOST_NEG) && (operand2 == '1);
    end

    // One restoring step: the shifted partial remainder needs WIDTH+1 bits,
    // but the difference always fits in WIDTH bits when it is taken.
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        rem_shift = {rem, dvd[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs});
        rem_sub   = rem_shift[WIDTH-1:0] - dvs;
    end

    // Final result selection with sign fix-up and forced special cases
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] fin_result;

    always_comb begin
        quot_fix = quot_neg ? -dvd : dvd;
        rem_fix  = rem_neg ? -rem : rem;
        if (div_zero)
            fin_result = opcode[1] ? dividend_raw : '1;
        else if (sgn_ovf)
            fin_result = opcode[1] ? '0 : MOST_NEG;
        else
            fin_result = opcode[1] ? rem_fix : quot_fix;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (startE) begin
`ifdef DIV_EARLY_OUT_EN
                    state_next = (in_div_zero || in_sgn_ovf) ? FIN : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC:    if (count == LAST_ITER) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        div_use = (state != IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode        <= '0;
            dvd           <= '0;
            dvs           <= '0;
            rem           <= '0;
            dividend_raw  <= '0;
            quot_neg      <= 1'b0;
            rem_neg       <= 1'b0;
            div_zero      <= 1'b0;
            sgn_ovf       <= 1'b0;
            count         <= '0;
            result_divide <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (startE) begin
                        opcode       <= div_opcode;
                        dvd          <= in_abs1;
                        dvs          <= in_abs2;
                        dividend_raw <= operand1;
                        quot_neg     <= in_op1_neg ^ in_op2_neg;
                        rem_neg      <= in_op1_neg;
                        div_zero     <= in_div_zero;
                        sgn_ovf      <= in_sgn_ovf;
                        rem          <= '0;
                        count        <= '0;
                    end
                end
                CALC: begin
                    rem   <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                    dvd   <= {dvd[WIDTH-2:0], rem_ge};
                    count <= count + CW'(1);
                end
                FIN: begin
                    result_divide <= fin_result;
                    done          <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iterative.sv
// tb_divider_iterative
//   Scoreboard bench for divider_iterative. Stimulus pushes the expected
//   result and completion cycle; a negedge monitor pops on every done pulse.
module tb_divider_iterative;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] MOST_NEG = 32'h8000_0000;

    logic         clk;
    logic         rst;
    logic         startE;
    logic [1:0]   div_opcode;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic [W-1:0] result_divide;
    logic         done;
    logic         div_use;

    divider_iterative #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .startE        (startE),
        .div_opcode    (div_opcode),
        .operand1      (operand1),
        .operand2      (operand2),
        .result_divide (result_divide),
        .done          (done),
        .div_use       (div_use)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int unsigned  cyc;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    // Reference: RV32M semantics using native signed/unsigned arithmetic
    function automatic logic [W-1:0] model(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sbv;
        sa  = a;
        sbv = b;
        if (b == '0) return op[1] ? a : '1;
        if (!op[0] && a == MOST_NEG && b == '1) return op[1] ? '0 : MOST_NEG;
        case (op)
            2'd0:    return sa / sbv;
            2'd1:    return a / b;
            2'd2:    return sa % sbv;
            default: return a % b;
        endcase
    endfunction

    // Clock edges from launch edge to the edge that raises done
    function automatic int unsigned lat(input logic [1:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == '0 || (!op[0] && a == MOST_NEG && b == '1)) return 1;
`endif
        return 33;
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                compared++;
                if (result_divide !== e.res) begin
                    mismatched++;
                    $display("FAIL result op=%0d a=%h b=%h: got %h expected %h",
                             e.op, e.a, e.b, result_divide, e.res);
                end
                compared++;
                if (cyc != e.cyc) begin
                    mismatched++;
                    $display("FAIL latency op=%0d a=%h b=%h: done at cycle %0d expected %0d",
                             e.op, e.a, e.b, cyc, e.cyc);
                end
                compared++;
                if (div_use !== 1'b0) begin
                    mismatched++;
                    $display("FAIL div_use_in_done: got %b expected 0", div_use);
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Called at a negedge; returns just after the launch edge
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] want);
        exp_t e;
        div_opcode = op;
        operand1   = a;
        operand2   = b;
        startE     = 1'b1;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.res = want;
        e.cyc = cyc + 1 + lat(op, a, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        startE     = 1'b0;
        div_opcode = 2'($urandom_range(3));
        operand1   = $urandom;
        operand2   = $urandom;
    endtask

    // Returns at the negedge where done is seen
    task automatic wait_done(input string name);
        bit seen;
        bit busy_ok;
        seen    = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (div_use !== 1'b1) busy_ok = 1'b0;
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL %s_timeout: done=0 expected 1 within 40 cycles", name);
        end
        compared++;
        if (!busy_ok) begin
            mismatched++;
            $display("FAIL %s_div_use: got 0 while busy expected 1", name);
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] want;
    } vec_t;

    vec_t dir[14] = '{
        '{2'd0, 32'd100,       32'd7,         32'd14},
        '{2'd2, 32'd100,       32'd7,         32'd2},
        '{2'd0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
        '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
        '{2'd1, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC},
        '{2'd3, 32'hFFFF_FFF9, 32'd2,         32'd1},
        '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
        '{2'd1, 32'd5,         32'd0,         32'hFFFF_FFFF},
        '{2'd3, 32'd5,         32'd0,         32'd5},
        '{2'd0, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF},
        '{2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB},
        '{2'd0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
        '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1}
    };

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst        = 1'b1;
        startE     = 1'b0;
        div_opcode = '0;
        operand1   = '0;
        operand2   = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result_divide, '0);
        check("reset_done", {31'd0, done}, '0);
        check("reset_div_use", {31'd0, div_use}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, alternating back-to-back and gapped launches
        for (int i = 0; i < 14; i++) begin
            if (i % 2 == 1) @(negedge clk);
            issue(dir[i].op, dir[i].a, dir[i].b, dir[i].want);
            wait_done("directed");
        end

        // startE mid-operation must be ignored
        @(negedge clk);
        issue(2'd0, 32'd1000, 32'd3, 32'd333);
        repeat (9) @(negedge clk);
        div_opcode = 2'd3;
        operand1   = 32'd55;
        operand2   = 32'd0;
        startE     = 1'b1;
        @(posedge clk);
        #1;
        startE = 1'b0;
        wait_done("ignored_start");

        // Reset in the middle of an operation
        @(negedge clk);
        issue(2'd1, 32'd12345, 32'd7, 32'd1763);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midreset_result", result_divide, '0);
        check("midreset_done", {31'd0, done}, '0);
        check("midreset_div_use", {31'd0, div_use}, '0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(2'd1, 32'd9, 32'd3, 32'd3);
        wait_done("after_reset");

        // Randomised operations with biased special cases
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(7))
                0:       rb = '0;
                1:       begin ra = MOST_NEG; rb = '1; end
                2:       rb = W'($urandom_range(1, 15));
                3:       ra = W'($urandom_range(0, 255));
                default: ;
            endcase
            if ($urandom_range(1) == 1) repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(rop, ra, rb, model(rop, ra, rb));
            wait_done("random");
        end

        repeat (3) @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL outstanding: got %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
